// File: rtl/fence_loader.sv
// fence_loader: collects R and G1..G6 samples, hands the frame to the sorter and waits for finish_sort
module fence_loader #(
  parameter int COORD_W   = 10,
  parameter int NUM_FENCE = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [COORD_W-1:0]     X,
  input  logic [COORD_W-1:0]     Y,
  input  logic                   finish_sort,
  output logic                   busy,
  output logic [2*COORD_W-1:0]   R,
  output logic [2*COORD_W-1:0]   G1,
  output logic [2*COORD_W-1:0]   G2,
  output logic [2*COORD_W-1:0]   G3,
  output logic [2*COORD_W-1:0]   G4,
  output logic [2*COORD_W-1:0]   G5,
  output logic [2*COORD_W-1:0]   G6,
  output logic                   finish_load,
  output logic [7:0]             frame_cnt
);
  typedef enum logic [1:0] {LOAD, HANDOFF, WAIT_SORT} state_t;
  state_t state, state_nx;
  logic [2:0] ptr;
  logic [2*COORD_W-1:0] pts [0:NUM_FENCE];
  logic accept, last;
  always_comb begin
    accept      = state == LOAD && in_valid;
    last        = ptr == 3'(NUM_FENCE);
    busy        = state != LOAD;
    finish_load = state == HANDOFF;
    state_nx    = state == LOAD    ? (accept && last ? HANDOFF : LOAD) :
                  state == HANDOFF ? WAIT_SORT :
                  finish_sort      ? LOAD : WAIT_SORT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      ptr       <= '0;
      frame_cnt <= '0;
      for (int i = 0; i <= NUM_FENCE; i++) pts[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        pts[ptr] <= {X, Y};
        ptr      <= last ? 3'd0 : ptr + 3'd1;
      end
      if (finish_load) frame_cnt <= frame_cnt + 8'd1;
    end
  end
  assign R  = pts[0];
  assign G1 = pts[1];
  assign G2 = pts[2];
  assign G3 = pts[3];
  assign G4 = pts[4];
  assign G5 = pts[5];
  assign G6 = pts[6];
endmodule

// File: tb/tb_fence_loader.sv
// tb_fence_loader: randomized scenarios against a slot-fill model of the fence loader
module tb_fence_loader;
  localparam int W = 10;
  logic clk = 0, reset = 0, in_valid = 0, finish_sort = 0;
  logic [W-1:0] X = '0, Y = '0;
  logic busy, finish_load;
  logic [2*W-1:0] R, G1, G2, G3, G4, G5, G6;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0;
  logic [2*W-1:0] m_pts [7];
  int m_fill = 0, m_frames = 0;
  int pulses = 0, doubles = 0;
  logic prev_fl = 0;

  always #5 clk = ~clk;

  fence_loader #(.COORD_W(W), .NUM_FENCE(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .Y(Y),
    .finish_sort(finish_sort), .busy(busy), .R(R), .G1(G1), .G2(G2),
    .G3(G3), .G4(G4), .G5(G5), .G6(G6), .finish_load(finish_load),
    .frame_cnt(frame_cnt)
  );

  always @(posedge clk) begin
    if (finish_load) pulses <= pulses + 1;
    if (finish_load && prev_fl) doubles <= doubles + 1;
    prev_fl <= finish_load;
  end

  function automatic logic [14*W-1:0] m_all();
    m_all = {m_pts[0], m_pts[1], m_pts[2], m_pts[3], m_pts[4], m_pts[5], m_pts[6]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_fill = 0;
    m_frames = 0;
    foreach (m_pts[i]) m_pts[i] = '0;
  endtask

  // gap_mode: 0 none, 1 alternating 1/3 idle cycles, 2 random 0..3
  task automatic send(input int n, input int gap_mode, input bit rnd);
    int gaps;
    logic full;
    for (int i = 0; i < n; i++) begin
      gaps = gap_mode == 0 ? 0 : gap_mode == 1 ? (i == 0 ? 0 : (i % 2 ? 1 : 3)) : int'($urandom_range(3));
      repeat (gaps) begin
        in_valid = 0;
        X = W'($urandom);
        Y = W'($urandom);
        tick();
        checks++;
        if (finish_load !== 1'b0 || busy !== 1'b0 || {R, G1, G2, G3, G4, G5, G6} !== m_all()) begin
          errors++;
          $display("FAIL gap: fl=%b busy=%b pts=%h, want fl=0 busy=0 pts=%h", finish_load, busy,
                   {R, G1, G2, G3, G4, G5, G6}, m_all());
        end
      end
      in_valid = 1;
      X = rnd ? W'($urandom) : W'(i + 1);
      Y = rnd ? W'($urandom) : W'(i + 10);
      tick();
      m_pts[m_fill] = {X, Y};
      m_fill++;
      full = m_fill == 7;
      if (full) m_fill = 0;
      in_valid = 0;
      checks++;
      if (finish_load !== full || busy !== full || {R, G1, G2, G3, G4, G5, G6} !== m_all()) begin
        errors++;
        $display("FAIL accept: fl=%b busy=%b pts=%h, want fl=%b busy=%b pts=%h", finish_load, busy,
                 {R, G1, G2, G3, G4, G5, G6}, full, full, m_all());
      end
    end
  endtask

  task automatic handoff();
    tick();
    m_frames = (m_frames + 1) % 256;
    checks++;
    if (finish_load !== 1'b0 || busy !== 1'b1 || frame_cnt !== 8'(m_frames)) begin
      errors++;
      $display("FAIL handoff: fl=%b busy=%b cnt=%0d, want fl=0 busy=1 cnt=%0d", finish_load, busy,
               frame_cnt, m_frames);
    end
  endtask

  task automatic sort_done(input int d);
    repeat (d) begin
      in_valid = 1'($urandom);
      X = W'($urandom);
      Y = W'($urandom);
      tick();
      checks++;
      if (busy !== 1'b1 || finish_load !== 1'b0 || {R, G1, G2, G3, G4, G5, G6} !== m_all()) begin
        errors++;
        $display("FAIL wait: busy=%b fl=%b pts=%h, want busy=1 fl=0 pts=%h", busy, finish_load,
                 {R, G1, G2, G3, G4, G5, G6}, m_all());
      end
    end
    finish_sort = 1;
    in_valid = 1;
    X = '1;
    Y = '1;
    tick();
    finish_sort = 0;
    in_valid = 0;
    checks++;
    if (busy !== 1'b0 || finish_load !== 1'b0 || {R, G1, G2, G3, G4, G5, G6} !== m_all()) begin
      errors++;
      $display("FAIL sort_done: busy=%b fl=%b pts=%h, want busy=0 fl=0 pts=%h", busy, finish_load,
               {R, G1, G2, G3, G4, G5, G6}, m_all());
    end
  endtask

  task automatic check_const_frame(input string name);
    checks++;
    if (R !== 20'h0040A || G1 !== {10'd2, 10'd11} || G6 !== {10'd7, 10'd16}) begin
      errors++;
      $display("FAIL %s: R=%h G1=%h G6=%h, want R=0040a G1=%h G6=%h", name, R, G1, G6,
               {10'd2, 10'd11}, {10'd7, 10'd16});
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({R, G1, G2, G3, G4, G5, G6} !== '0 || busy !== 1'b0 || finish_load !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s: pts=%h busy=%b fl=%b cnt=%0d, want all zero", name,
               {R, G1, G2, G3, G4, G5, G6}, busy, finish_load, frame_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    in_valid = 1;
    X = W'($urandom);
    Y = W'($urandom);
    repeat (2) tick();
    m_reset();
    check_zero("reset");
    reset = 1;
    in_valid = 0;
  endtask

  task automatic test_back_to_back();
    send(7, 0, 0);
    check_const_frame("b2b_values");
    handoff();
    sort_done(2);
  endtask

  task automatic test_gaps();
    send(7, 1, 0);
    check_const_frame("gap_values");
    handoff();
    sort_done(0);
  endtask

  task automatic test_wait_sort_ignore();
    logic [2*W-1:0] g1_hold;
    send(7, 2, 1);
    handoff();
    repeat (20) begin
      in_valid = 1;
      X = '1;
      Y = '1;
      tick();
      checks++;
      if (busy !== 1'b1 || {R, G1, G2, G3, G4, G5, G6} !== m_all()) begin
        errors++;
        $display("FAIL wait_ignore: busy=%b pts=%h, want busy=1 pts=%h", busy,
                 {R, G1, G2, G3, G4, G5, G6}, m_all());
      end
    end
    sort_done(0);
    g1_hold = G1;
    send(1, 0, 1);
    checks++;
    if (R !== {X, Y} || G1 !== g1_hold) begin
      errors++;
      $display("FAIL first_after_sort: R=%h G1=%h, want R=%h G1=%h", R, G1, {X, Y}, g1_hold);
    end
    send(6, 2, 1);
    handoff();
    sort_done(1);
  endtask

  task automatic test_sort_in_load();
    send(3, 0, 1);
    finish_sort = 1;
    tick();
    finish_sort = 0;
    checks++;
    if (busy !== 1'b0 || finish_load !== 1'b0 || {R, G1, G2, G3, G4, G5, G6} !== m_all()) begin
      errors++;
      $display("FAIL sort_in_load: busy=%b fl=%b pts=%h, want busy=0 fl=0 pts=%h", busy, finish_load,
               {R, G1, G2, G3, G4, G5, G6}, m_all());
    end
    send(4, 0, 1);
    handoff();
    sort_done(3);
  endtask

  task automatic test_mid_reset();
    send(4, 0, 1);
    reset = 0;
    in_valid = 1;
    X = W'($urandom);
    Y = W'($urandom);
    tick();
    m_reset();
    check_zero("mid_reset");
    reset = 1;
    in_valid = 0;
    tick();
    check_zero("after_reset");
    send(7, 2, 1);
    handoff();
    sort_done(1);
  endtask

  task automatic test_frames257();
    int p0, d0;
    reset = 0;
    tick();
    reset = 1;
    m_reset();
    p0 = pulses;
    d0 = doubles;
    repeat (257) begin
      send(7, 0, 1);
      handoff();
      sort_done(3);
    end
    checks++;
    if (frame_cnt !== 8'd1 || pulses - p0 !== 257 || doubles !== d0) begin
      errors++;
      $display("FAIL frames257: cnt=%0d pulses=%0d wide=%0d, want cnt=1 pulses=257 wide=0", frame_cnt,
               pulses - p0, doubles - d0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_wait_sort_ignore();
    test_sort_in_load();
    test_mid_reset();
    test_frames257();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
